// File: rtl/csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive packet sequencer.
package csi_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_FOOTER,
        ST_DONE
    } pkt_state_t;

    // Synchronisation short-packet data types
    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;
    localparam logic [5:0] DT_LS = 6'h02;
    localparam logic [5:0] DT_LE = 6'h03;

    // Byte positions inside the 4-byte packet header
    localparam logic [1:0] HDR_IDX_DI    = 2'd0;
    localparam logic [1:0] HDR_IDX_WC_LO = 2'd1;
    localparam logic [1:0] HDR_IDX_WC_HI = 2'd2;
    localparam logic [1:0] HDR_IDX_ECC   = 2'd3;

endpackage

// File: rtl/csi_rx_packet_ctrl.sv
// Per-lane packet sequencer: splits the aligned byte stream into header,
// payload and footer, and drives the aligner's sync/done handshake.
module csi_rx_packet_ctrl
    import csi_rx_pkg::*;
#(
    parameter logic [15:0] MAX_WC      = 16'd8192,
    parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    output logic        wait_for_sync,
    output logic        packet_done,
    output logic        hdr_vld,
    output logic [1:0]  vc,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic [7:0]  ecc,
    output logic [7:0]  pl_data,
    output logic        pl_vld,
    output logic        pl_last,
    output logic [15:0] crc,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        pkt_err
);

    pkt_state_t  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  wc_lo_q, wc_lo_d;
    logic [7:0]  wc_hi_q, wc_hi_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic [1:0]  vc_q, vc_d;
    logic [5:0]  dt_q, dt_d;
    logic [15:0] wc_q, wc_d;
    logic [7:0]  ecc_q, ecc_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_vld_q, pl_vld_d;
    logic        pl_last_q, pl_last_d;
    logic        hdr_vld_q, hdr_vld_d;
    logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
    logic        pkt_err_q, pkt_err_d;

    logic [15:0] hdr_wc;
    logic        hdr_is_long;

    assign hdr_wc      = {wc_hi_q, wc_lo_q};
    assign hdr_is_long = (di_q[5:0] >= LONG_DT_MIN);

    // Next-state, counter and output computation; pulses default low every clock
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        di_d      = di_q;
        wc_lo_d   = wc_lo_q;
        wc_hi_d   = wc_hi_q;
        crc_lo_d  = crc_lo_q;
        vc_d      = vc_q;
        dt_d      = dt_q;
        wc_d      = wc_q;
        ecc_d     = ecc_q;
        crc_d     = crc_q;
        pl_data_d = pl_data_q;
        pl_vld_d  = 1'b0;
        pl_last_d = 1'b0;
        hdr_vld_d = 1'b0;
        fs_d      = 1'b0;
        fe_d      = 1'b0;
        ls_d      = 1'b0;
        le_d      = 1'b0;
        pkt_err_d = 1'b0;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_vld) begin
                        di_d    = byte_in;
                        idx_d   = HDR_IDX_WC_LO;
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!byte_vld) begin
                        pkt_err_d = 1'b1;
                        idx_d     = HDR_IDX_DI;
                        state_d   = ST_IDLE;
                    end else if (idx_q == HDR_IDX_WC_LO) begin
                        wc_lo_d = byte_in;
                        idx_d   = HDR_IDX_WC_HI;
                    end else if (idx_q == HDR_IDX_WC_HI) begin
                        wc_hi_d = byte_in;
                        idx_d   = HDR_IDX_ECC;
                    end else begin
                        // ECC byte completes the header: publish all fields at once
                        ecc_d     = byte_in;
                        vc_d      = di_q[7:6];
                        dt_d      = di_q[5:0];
                        wc_d      = hdr_wc;
                        hdr_vld_d = 1'b1;
                        fs_d      = (di_q[5:0] == DT_FS);
                        fe_d      = (di_q[5:0] == DT_FE);
                        ls_d      = (di_q[5:0] == DT_LS);
                        le_d      = (di_q[5:0] == DT_LE);
                        idx_d     = HDR_IDX_DI;
                        if (!hdr_is_long) begin
                            state_d = ST_DONE;
                        end else if (hdr_wc == 16'd0) begin
                            state_d = ST_FOOTER;
                        end else if (hdr_wc > MAX_WC) begin
                            pkt_err_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            rem_d   = hdr_wc;
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!byte_vld) begin
                        pkt_err_d = 1'b1;
                        rem_d     = 16'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        pl_vld_d  = 1'b1;
                        pl_data_d = byte_in;
                        if (rem_q == 16'd1) begin
                            pl_last_d = 1'b1;
                            rem_d     = 16'd0;
                            state_d   = ST_FOOTER;
                        end else begin
                            rem_d = rem_q - 16'd1;
                        end
                    end
                end
                ST_FOOTER: begin
                    if (!byte_vld) begin
                        pkt_err_d = 1'b1;
                        idx_d     = HDR_IDX_DI;
                        state_d   = ST_IDLE;
                    end else if (idx_q == 2'd0) begin
                        crc_lo_d = byte_in;
                        idx_d    = 2'd1;
                    end else begin
                        crc_d   = {byte_in, crc_lo_q};
                        idx_d   = HDR_IDX_DI;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The byte presented here is deliberately dropped
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = HDR_IDX_DI;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= HDR_IDX_DI;
            rem_q     <= 16'd0;
            di_q      <= 8'd0;
            wc_lo_q   <= 8'd0;
            wc_hi_q   <= 8'd0;
            crc_lo_q  <= 8'd0;
            vc_q      <= 2'd0;
            dt_q      <= 6'd0;
            wc_q      <= 16'd0;
            ecc_q     <= 8'd0;
            crc_q     <= 16'd0;
            pl_data_q <= 8'd0;
            pl_vld_q  <= 1'b0;
            pl_last_q <= 1'b0;
            hdr_vld_q <= 1'b0;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            ls_q      <= 1'b0;
            le_q      <= 1'b0;
            pkt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            di_q      <= di_d;
            wc_lo_q   <= wc_lo_d;
            wc_hi_q   <= wc_hi_d;
            crc_lo_q  <= crc_lo_d;
            vc_q      <= vc_d;
            dt_q      <= dt_d;
            wc_q      <= wc_d;
            ecc_q     <= ecc_d;
            crc_q     <= crc_d;
            pl_data_q <= pl_data_d;
            pl_vld_q  <= pl_vld_d;
            pl_last_q <= pl_last_d;
            hdr_vld_q <= hdr_vld_d;
            fs_q      <= fs_d;
            fe_q      <= fe_d;
            ls_q      <= ls_d;
            le_q      <= le_d;
            pkt_err_q <= pkt_err_d;
        end
    end

    assign wait_for_sync = (state_q == ST_IDLE);
    assign packet_done   = (state_q == ST_DONE);
    assign hdr_vld       = hdr_vld_q;
    assign vc            = vc_q;
    assign data_type     = dt_q;
    assign word_count    = wc_q;
    assign ecc           = ecc_q;
    assign pl_data       = pl_data_q;
    assign pl_vld        = pl_vld_q;
    assign pl_last       = pl_last_q;
    assign crc           = crc_q;
    assign frame_start   = fs_q;
    assign frame_end     = fe_q;
    assign line_start    = ls_q;
    assign line_end      = le_q;
    assign pkt_err       = pkt_err_q;

endmodule

// File: tb/tb_csi_rx_packet_ctrl.sv
// Directed testbench for csi_rx_packet_ctrl.
module tb_csi_rx_packet_ctrl;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [7:0]  byte_in;
    logic        byte_vld;
    logic        wait_for_sync;
    logic        packet_done;
    logic        hdr_vld;
    logic [1:0]  vc;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic [7:0]  ecc;
    logic [7:0]  pl_data;
    logic        pl_vld;
    logic        pl_last;
    logic [15:0] crc;
    logic        frame_start;
    logic        frame_end;
    logic        line_start;
    logic        line_end;
    logic        pkt_err;

    int errors = 0;
    int checks = 0;

    csi_rx_packet_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .byte_in       (byte_in),
        .byte_vld      (byte_vld),
        .wait_for_sync (wait_for_sync),
        .packet_done   (packet_done),
        .hdr_vld       (hdr_vld),
        .vc            (vc),
        .data_type     (data_type),
        .word_count    (word_count),
        .ecc           (ecc),
        .pl_data       (pl_data),
        .pl_vld        (pl_vld),
        .pl_last       (pl_last),
        .crc           (crc),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .line_start    (line_start),
        .line_end      (line_end),
        .pkt_err       (pkt_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one input sample, then observe outputs 1 ns after the edge
    task automatic drive(input logic en, input logic vld, input logic [7:0] b);
        enable   = en;
        byte_vld = vld;
        byte_in  = b;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        byte_vld = 1'b0;
        byte_in  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (wait_for_sync !== 1'b1) begin errors++; $display("FAIL reset_wait got=%b exp=1", wait_for_sync); end
        checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", packet_done); end
        checks++; if ({hdr_vld, pl_vld, pkt_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {hdr_vld, pl_vld, pkt_err}); end
        checks++; if ({word_count, crc, ecc, pl_data} !== 48'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {word_count, crc, ecc, pl_data}); end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        $display("txn reset done");
    endtask

    task automatic test_short_fs();
        drive(1'b1, 1'b1, 8'h00);
        checks++; if (wait_for_sync !== 1'b0) begin errors++; $display("FAIL fs_wait_low got=%b exp=0", wait_for_sync); end
        drive(1'b1, 1'b1, 8'h05);
        drive(1'b1, 1'b1, 8'h00);
        checks++; if (hdr_vld !== 1'b0) begin errors++; $display("FAIL fs_hdr_early got=%b exp=0", hdr_vld); end
        drive(1'b1, 1'b1, 8'hAB);
        checks++; if ({hdr_vld, frame_start, frame_end, line_start, line_end} !== 5'b11000) begin errors++; $display("FAIL fs_pulses got=%b exp=11000", {hdr_vld, frame_start, frame_end, line_start, line_end}); end
        checks++; if (word_count !== 16'h0005) begin errors++; $display("FAIL fs_wc got=%h exp=0005", word_count); end
        checks++; if (ecc !== 8'hAB) begin errors++; $display("FAIL fs_ecc got=%h exp=ab", ecc); end
        checks++; if ({vc, data_type} !== 8'h00) begin errors++; $display("FAIL fs_di got=%h exp=00", {vc, data_type}); end
        checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL fs_done got=%b exp=1", packet_done); end
        drive(1'b1, 1'b1, 8'h77);
        checks++; if ({packet_done, wait_for_sync, hdr_vld, frame_start} !== 4'b0100) begin errors++; $display("FAIL fs_return got=%b exp=0100", {packet_done, wait_for_sync, hdr_vld, frame_start}); end
        $display("txn short FS word_count=%h ecc=%h", word_count, ecc);
    endtask

    // Long packet DI=0x2A WC=4; optionally with a disabled cycle before every byte
    task automatic test_long(input bit stall);
        logic [7:0] seq [10];
        logic [7:0] exp_pl [4];
        int n_pl;
        int n_last;
        int n_hdr;
        int n_done;
        seq = '{8'h2A, 8'h04, 8'h00, 8'hE0, 8'h11, 8'h22, 8'h33, 8'h44, 8'hCD, 8'hEF};
        exp_pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        n_pl = 0; n_last = 0; n_hdr = 0; n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (stall) begin
                drive(1'b0, 1'b1, 8'hFF);
                checks++; if ({hdr_vld, pl_vld, pl_last, pkt_err} !== 4'b0000) begin errors++; $display("FAIL long_stall_pulse i=%0d got=%b exp=0000", i, {hdr_vld, pl_vld, pl_last, pkt_err}); end
            end
            drive(1'b1, 1'b1, seq[i]);
            if (hdr_vld) n_hdr++;
            if (packet_done) n_done++;
            if (pl_vld) begin
                if (n_pl < 4) begin
                    checks++; if (pl_data !== exp_pl[n_pl]) begin errors++; $display("FAIL long_pl_data n=%0d got=%h exp=%h", n_pl, pl_data, exp_pl[n_pl]); end
                end
                if (pl_last) begin
                    n_last++;
                    checks++; if (pl_data !== 8'h44) begin errors++; $display("FAIL long_last_byte got=%h exp=44", pl_data); end
                end
                n_pl++;
            end
            if (i == 3) begin
                checks++; if ({hdr_vld, vc, data_type, word_count} !== {1'b1, 8'h2A, 16'h0004}) begin errors++; $display("FAIL long_hdr got=%b/%h/%h exp=1/2a/0004", hdr_vld, {vc, data_type}, word_count); end
            end
        end
        checks++; if (n_pl !== 4) begin errors++; $display("FAIL long_pl_count got=%0d exp=4", n_pl); end
        checks++; if (n_last !== 1) begin errors++; $display("FAIL long_last_count got=%0d exp=1", n_last); end
        checks++; if (n_hdr !== 1) begin errors++; $display("FAIL long_hdr_count got=%0d exp=1", n_hdr); end
        checks++; if (packet_done !== 1'b1 || n_done !== 1) begin errors++; $display("FAIL long_done got=%b cnt=%0d exp=1/1", packet_done, n_done); end
        checks++; if (crc !== 16'hEFCD) begin errors++; $display("FAIL long_crc got=%h exp=efcd", crc); end
        if (stall) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL long_done_hold got=%b exp=1", packet_done); end
        end
        drive(1'b1, 1'b1, 8'h00);
        checks++; if ({packet_done, wait_for_sync} !== 2'b01) begin errors++; $display("FAIL long_return got=%b exp=01", {packet_done, wait_for_sync}); end
        $display("txn long stall=%0d payload=%0d crc=%h", stall, n_pl, crc);
    endtask

    task automatic test_wc_zero();
        int n_pl;
        n_pl = 0;
        drive(1'b1, 1'b1, 8'h2B);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h3C);
        checks++; if ({hdr_vld, packet_done, wait_for_sync} !== 3'b100) begin errors++; $display("FAIL wc0_hdr got=%b exp=100", {hdr_vld, packet_done, wait_for_sync}); end
        drive(1'b1, 1'b1, 8'h01);
        if (pl_vld) n_pl++;
        checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL wc0_mid_done got=%b exp=0", packet_done); end
        drive(1'b1, 1'b1, 8'h02);
        if (pl_vld) n_pl++;
        checks++; if (n_pl !== 0) begin errors++; $display("FAIL wc0_payload got=%0d exp=0", n_pl); end
        checks++; if ({packet_done, crc} !== {1'b1, 16'h0201}) begin errors++; $display("FAIL wc0_done got=%b/%h exp=1/0201", packet_done, crc); end
        drive(1'b1, 1'b1, 8'h00);
        $display("txn wc0 crc=%h", crc);
    endtask

    task automatic test_oversize();
        drive(1'b1, 1'b1, 8'h2A);
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 8'h20);
        drive(1'b1, 1'b1, 8'h55);
        checks++; if ({hdr_vld, pkt_err, packet_done, pl_vld} !== 4'b1110) begin errors++; $display("FAIL big_pulses got=%b exp=1110", {hdr_vld, pkt_err, packet_done, pl_vld}); end
        checks++; if (word_count !== 16'h2001) begin errors++; $display("FAIL big_wc got=%h exp=2001", word_count); end
        drive(1'b1, 1'b1, 8'h99);
        checks++; if ({pkt_err, pl_vld, packet_done, wait_for_sync} !== 4'b0001) begin errors++; $display("FAIL big_return got=%b exp=0001", {pkt_err, pl_vld, packet_done, wait_for_sync}); end
        $display("txn oversize word_count=%h", word_count);
    endtask

    task automatic test_max_wc_edge();
        // WC == MAX_WC (0x2000) is legal: enters payload with no error
        drive(1'b1, 1'b1, 8'h2A);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h20);
        drive(1'b1, 1'b1, 8'h66);
        checks++; if ({hdr_vld, pkt_err, packet_done} !== 3'b100) begin errors++; $display("FAIL maxwc_hdr got=%b exp=100", {hdr_vld, pkt_err, packet_done}); end
        drive(1'b1, 1'b1, 8'h5A);
        checks++; if ({pl_vld, pl_last, pl_data} !== {2'b10, 8'h5A}) begin errors++; $display("FAIL maxwc_pl got=%b%b/%h exp=10/5a", pl_vld, pl_last, pl_data); end
        drive(1'b1, 1'b0, 8'h00);
        checks++; if ({pkt_err, wait_for_sync, packet_done} !== 3'b110) begin errors++; $display("FAIL maxwc_abort got=%b exp=110", {pkt_err, wait_for_sync, packet_done}); end
        drive(1'b1, 1'b0, 8'h00);
        $display("txn max_wc edge");
    endtask

    task automatic test_lock_loss();
        int n_pl;
        n_pl = 0;
        drive(1'b1, 1'b1, 8'h2A);
        drive(1'b1, 1'b1, 8'h04);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'hE0);
        drive(1'b1, 1'b1, 8'h11);
        if (pl_vld) n_pl++;
        drive(1'b1, 1'b1, 8'h22);
        if (pl_vld) n_pl++;
        checks++; if (n_pl !== 2) begin errors++; $display("FAIL lock_pl_count got=%0d exp=2", n_pl); end
        drive(1'b1, 1'b0, 8'h33);
        checks++; if ({pkt_err, wait_for_sync, packet_done, pl_vld} !== 4'b1100) begin errors++; $display("FAIL lock_abort got=%b exp=1100", {pkt_err, wait_for_sync, packet_done, pl_vld}); end
        drive(1'b1, 1'b0, 8'h44);
        checks++; if ({pkt_err, packet_done} !== 2'b00) begin errors++; $display("FAIL lock_after got=%b exp=00", {pkt_err, packet_done}); end
        // Lock lost on the final footer byte
        drive(1'b1, 1'b1, 8'h2B);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h12);
        drive(1'b1, 1'b1, 8'h34);
        drive(1'b1, 1'b0, 8'h56);
        checks++; if ({pkt_err, packet_done, wait_for_sync} !== 3'b101) begin errors++; $display("FAIL lock_footer got=%b exp=101", {pkt_err, packet_done, wait_for_sync}); end
        drive(1'b1, 1'b0, 8'h00);
        $display("txn lock loss");
    endtask

    task automatic test_back_to_back();
        logic [5:0] dts [3];
        logic [3:0] exp_m [3];
        dts   = '{6'h02, 6'h03, 6'h01};
        exp_m = '{4'b0010, 4'b0001, 4'b0100};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, {2'b01, dts[k]});
            drive(1'b1, 1'b1, 8'h10 + 8'(k));
            drive(1'b1, 1'b1, 8'h00);
            drive(1'b1, 1'b1, 8'hC0);
            checks++; if ({frame_start, frame_end, line_start, line_end} !== exp_m[k]) begin errors++; $display("FAIL b2b_marker k=%0d got=%b exp=%b", k, {frame_start, frame_end, line_start, line_end}, exp_m[k]); end
            checks++; if ({hdr_vld, vc, word_count} !== {1'b1, 2'b01, 16'h0010 + 16'(k)}) begin errors++; $display("FAIL b2b_hdr k=%0d got=%b/%0d/%h", k, hdr_vld, vc, word_count); end
            drive(1'b1, 1'b1, 8'hEE);
            $display("txn short dt=%h vc=%0d", dts[k], vc);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 8'h2A);
        drive(1'b1, 1'b1, 8'h04);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'hE0);
        drive(1'b1, 1'b1, 8'h11);
        checks++; if (pl_vld !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", pl_vld); end
        reset_n = 1'b0;
        #1;
        checks++; if ({wait_for_sync, packet_done, pl_vld, hdr_vld, pkt_err} !== 5'b10000) begin errors++; $display("FAIL rstmid_ctrl got=%b exp=10000", {wait_for_sync, packet_done, pl_vld, hdr_vld, pkt_err}); end
        checks++; if ({word_count, crc, pl_data, ecc, vc, data_type} !== 56'd0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", {word_count, crc, pl_data, ecc, vc, data_type}); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h07);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h42);
        checks++; if ({hdr_vld, frame_start, word_count} !== {2'b11, 16'h0007}) begin errors++; $display("FAIL rstmid_recover got=%b%b/%h exp=11/0007", hdr_vld, frame_start, word_count); end
        $display("txn reset mid-payload");
    endtask

    initial begin
        test_reset();
        test_short_fs();
        test_long(1'b0);
        test_long(1'b1);
        test_wc_zero();
        test_oversize();
        test_max_wc_edge();
        test_lock_loss();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
